prdec_grant: RTL and testbench

PRDEC_GRANT -- requirements
Module: prdec_grant

---
 rtl/prdec_grant.sv | 121 ++++++++++++
 tb/tb_prdec_grant.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prdec_grant.sv
// prdec_grant: turns a 4:2 priority-encoder code {A,B,Y} into a registered
// one-hot grant. Each grant is held until the requester releases it with
// DONE, or until HOLD_MAX cycles have passed (timeout). A mandatory
// one-cycle RELEASE gap separates back-to-back grants. GCNT counts issued
// grants and saturates instead of wrapping.
module prdec_grant #(
  parameter int HOLD_MAX = 15,  // maximum grant length in cycles, 2..255
  parameter int CNT_W    = 8    // width of the grant counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             Y,
  input  logic             DONE,
  output logic             G0,
  output logic             G1,
  output logic             G2,
  output logic             G3,
  output logic             BUSY,
  output logic             TOUT,
  output logic [CNT_W-1:0] GCNT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // HOLD_MAX is at most 255, so an 8-bit hold counter always suffices.
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] GCNT_MAX  = '1;

  state_t           state_reg, state_next;
  logic [3:0]       g_reg, g_next;
  logic             tout_reg, tout_next;
  logic [CNT_W-1:0] gcnt_reg, gcnt_next;
  logic [7:0]       hold_reg, hold_next;
  logic [3:0]       code_onehot;

  // Code decode: bit gi of the one-hot is selected by code 3-gi, so
  // {A,B}=11 -> G0, 10 -> G1, 01 -> G2, 00 -> G3.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_decode
      localparam logic [1:0] CODE = 2'(3 - gi);
      assign code_onehot[gi] = ({A, B} == CODE);
    end
  endgenerate

  // Next-state and next-output logic for the IDLE/GRANT/RELEASE sequence.
  always_comb begin
    state_next = state_reg;
    g_next     = g_reg;
    tout_next  = 1'b0;
    gcnt_next  = gcnt_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        g_next = 4'b0000;
        if (Y) begin
          state_next = GRANT;
          g_next     = code_onehot;
          hold_next  = 8'd0;
          if (gcnt_reg != GCNT_MAX) begin
            gcnt_next = gcnt_reg + 1'b1;
          end
        end
      end
      GRANT: begin
        // Code inputs are ignored here; only DONE or the timeout ends it.
        // DONE is tested first so that it wins over a coincident timeout.
        if (DONE) begin
          state_next = RELEASE;
          g_next     = 4'b0000;
        end else if (hold_reg == HOLD_LAST) begin
          state_next = RELEASE;
          g_next     = 4'b0000;
          tout_next  = 1'b1;
        end else begin
          hold_next = hold_reg + 8'd1;
        end
      end
      RELEASE: begin
        g_next     = 4'b0000;
        state_next = IDLE;
      end
      default: begin
        g_next     = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      g_reg     <= 4'b0000;
      tout_reg  <= 1'b0;
      gcnt_reg  <= '0;
      hold_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      g_reg     <= g_next;
      tout_reg  <= tout_next;
      gcnt_reg  <= gcnt_next;
      hold_reg  <= hold_next;
    end
  end

  assign G0   = g_reg[0];
  assign G1   = g_reg[1];
  assign G2   = g_reg[2];
  assign G3   = g_reg[3];
  assign BUSY = (state_reg != IDLE);
  assign TOUT = tout_reg;
  assign GCNT = gcnt_reg;

endmodule

// File: tb/tb_prdec_grant.sv
// Directed bench for prdec_grant: a default-parameter instance plus a
// CNT_W=2 instance that shares its stimulus for the saturation scenario.
module tb_prdec_grant;

  logic clk = 1'b0;
  logic rst, a, b, y, done;

  logic g0, g1, g2, g3, busy, tout;
  logic [7:0] gcnt;
  logic s_g0, s_g1, s_g2, s_g3, s_busy, s_tout;
  logic [1:0] s_gcnt;

  logic [3:0] g;
  assign g = {g3, g2, g1, g0};

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prdec_grant #(.HOLD_MAX(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .Y(y), .DONE(done),
    .G0(g0), .G1(g1), .G2(g2), .G3(g3),
    .BUSY(busy), .TOUT(tout), .GCNT(gcnt)
  );

  prdec_grant #(.HOLD_MAX(15), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .A(a), .B(b), .Y(y), .DONE(done),
    .G0(s_g0), .G1(s_g1), .G2(s_g2), .G3(s_g3),
    .BUSY(s_busy), .TOUT(s_tout), .GCNT(s_gcnt)
  );

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 1'b1; b = 1'b1; y = 1'b1; done = 1'b1;
    cyc();
    cyc();
    vectors++;
    if ({g, busy, tout} !== 6'b0 || gcnt !== 8'd0 || s_gcnt !== 2'd0) begin
      miscompares++;
      $display("FAIL reset: g=%b busy=%b tout=%b gcnt=%0d s_gcnt=%0d, want all 0",
               g, busy, tout, gcnt, s_gcnt);
    end
  endtask

  // Four codes; the first is applied in the very first cycle after reset.
  task automatic test_decode();
    logic [1:0] codes [4];
    logic [3:0] exp_g [4];
    codes = '{2'b11, 2'b10, 2'b01, 2'b00};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      rst = 1'b0; done = 1'b0;
      {a, b} = codes[i]; y = 1'b1;
      cyc();
      vectors++;
      if (g !== exp_g[i] || busy !== 1'b1 || gcnt !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL decode_grant%0d: g=%b busy=%b gcnt=%0d, want g=%b busy=1 gcnt=%0d",
                 i, g, busy, gcnt, exp_g[i], i + 1);
      end
      y = 1'b0;
      cyc();
      vectors++;
      if (g !== exp_g[i]) begin
        miscompares++;
        $display("FAIL decode_hold%0d: g=%b, want %b", i, g, exp_g[i]);
      end
      done = 1'b1;
      cyc();
      vectors++;
      if (g !== 4'b0000 || busy !== 1'b1 || tout !== 1'b0) begin
        miscompares++;
        $display("FAIL decode_release%0d: g=%b busy=%b tout=%b, want g=0 busy=1 tout=0",
                 i, g, busy, tout);
      end
      // DONE still high in RELEASE must not matter.
      cyc();
      done = 1'b0;
      vectors++;
      if (g !== 4'b0000 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL decode_idle%0d: g=%b busy=%b, want g=0 busy=0", i, g, busy);
      end
    end
    vectors++;
    if (gcnt !== 8'd4) begin
      miscompares++;
      $display("FAIL decode_gcnt: gcnt=%0d, want 4", gcnt);
    end
  endtask

  task automatic test_timeout();
    // DONE in IDLE has no effect.
    done = 1'b1; y = 1'b0;
    cyc();
    vectors++;
    if (busy !== 1'b0 || g !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_done: busy=%b g=%b, want 0/0", busy, g);
    end
    done = 1'b0; {a, b} = 2'b10; y = 1'b1;
    cyc();
    y = 1'b0;
    vectors++;
    if (g !== 4'b0010) begin
      miscompares++;
      $display("FAIL timeout_c1: g=%b, want 0010", g);
    end
    for (int c = 2; c <= 15; c++) begin
      cyc();
      vectors++;
      if (g !== 4'b0010 || tout !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_c%0d: g=%b tout=%b, want g=0010 tout=0", c, g, tout);
      end
    end
    cyc();
    vectors++;
    if (g !== 4'b0000 || tout !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_end: g=%b tout=%b busy=%b, want g=0 tout=1 busy=1", g, tout, busy);
    end
    cyc();
    vectors++;
    if (tout !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_after: tout=%b busy=%b, want 0/0", tout, busy);
    end
  endtask

  task automatic test_collision();
    {a, b} = 2'b11; y = 1'b1; done = 1'b0;
    cyc();
    y = 1'b0;
    for (int c = 2; c <= 15; c++) cyc();
    vectors++;
    if (g !== 4'b0001) begin
      miscompares++;
      $display("FAIL collision_c15: g=%b, want 0001", g);
    end
    done = 1'b1;
    cyc();
    done = 1'b0;
    vectors++;
    if (g !== 4'b0000 || tout !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_end: g=%b tout=%b busy=%b, want g=0 tout=0 busy=1", g, tout, busy);
    end
    cyc();
  endtask

  task automatic test_mid_change();
    {a, b} = 2'b00; y = 1'b1; done = 1'b0;
    cyc();
    {a, b} = 2'b11;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (g !== 4'b1000) begin
        miscompares++;
        $display("FAIL midchange_hold%0d: g=%b, want 1000", c, g);
      end
      cyc();
    end
    done = 1'b1;
    cyc();
    done = 1'b0;
    vectors++;
    if (g !== 4'b0000 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midchange_release: g=%b busy=%b, want g=0 busy=1", g, busy);
    end
    cyc();
    vectors++;
    if (g !== 4'b0000 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midchange_idle: g=%b busy=%b, want g=0 busy=0", g, busy);
    end
    cyc();
    vectors++;
    if (g !== 4'b0001) begin
      miscompares++;
      $display("FAIL midchange_regrant: g=%b, want 0001", g);
    end
    y = 1'b0; done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
  endtask

  task automatic test_mid_reset();
    {a, b} = 2'b01; y = 1'b1; done = 1'b0;
    cyc();
    y = 1'b0;
    cyc();
    vectors++;
    if (g !== 4'b0100) begin
      miscompares++;
      $display("FAIL midreset_pre: g=%b, want 0100", g);
    end
    cyc();
    rst = 1'b1; done = 1'b1; y = 1'b1;
    cyc();
    vectors++;
    if ({g, busy, tout} !== 6'b0 || gcnt !== 8'd0 || s_gcnt !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset: g=%b busy=%b tout=%b gcnt=%0d s_gcnt=%0d, want all 0",
               g, busy, tout, gcnt, s_gcnt);
    end
    rst = 1'b0; done = 1'b0; y = 1'b0;
    cyc();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s [5];
    exp_s = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      {a, b} = 2'b11; y = 1'b1; done = 1'b0;
      cyc();
      vectors++;
      if (s_gcnt !== exp_s[i] || s_g0 !== 1'b1 || gcnt !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL sat_grant%0d: s_gcnt=%0d s_g0=%b gcnt=%0d, want s_gcnt=%0d s_g0=1 gcnt=%0d",
                 i, s_gcnt, s_g0, gcnt, exp_s[i], i + 1);
      end
      y = 1'b0; done = 1'b1;
      cyc();
      done = 1'b0;
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_timeout();
    test_collision();
    test_mid_change();
    test_mid_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
